// File: rtl/seq_scan_ctrl.sv
// seq_scan_ctrl: round-robin job arbiter that streams each accepted word
// MSB-first into an external 101 sequence detector and reports how many
// matches the detector flagged.
module seq_scan_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [3:0]         req,
  input  logic [4*WIDTH-1:0] req_data,
  output logic [3:0]         gnt,
  output logic               det_x,
  input  logic               det_z,
  output logic               det_clr,
  output logic               busy,
  output logic               done,
  output logic [1:0]         done_id,
  output logic [CNT_W-1:0]   match_cnt
);

  localparam int BC_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CLEAR, SHIFT, DONE} state_t;

  state_t           state;
  logic [1:0]       last_winner;
  logic [1:0]       pick;
  logic [1:0]       job_id;
  logic [WIDTH-1:0] sreg;
  logic [BC_W-1:0]  bitcnt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             last_bit;

  // round-robin winner: scan downward so the requester nearest after
  // last_winner overrides the farther ones; last_winner itself is lowest
  always_comb begin
    pick = last_winner;
    for (int k = 4; k >= 1; k--)
      if (req[last_winner + 2'(k)]) pick = last_winner + 2'(k);
  end

  // grant is the acceptance pulse of the IDLE cycle; it must sample the
  // word in that same cycle, so it is decoded from state rather than
  // registered, and forced low while reset is held
  always_comb begin
    gnt = 4'b0000;
    if (reset_n && state == IDLE && |req) gnt = 4'b0001 << pick;
  end

  // saturating match count and end-of-word detect
  always_comb begin
    cnt_nxt  = (det_z && cnt != '1) ? cnt + 1'b1 : cnt;
    last_bit = (bitcnt == BC_W'(WIDTH - 1));
  end

  // job sequencer: IDLE -> CLEAR -> SHIFT x WIDTH -> DONE -> IDLE
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      last_winner <= 2'd3;
      job_id      <= 2'd0;
      sreg        <= '0;
      bitcnt      <= '0;
      cnt         <= '0;
      det_x       <= 1'b0;
      det_clr     <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      done_id     <= 2'd0;
      match_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            last_winner <= pick;
            job_id      <= pick;
            sreg        <= req_data[int'(pick)*WIDTH +: WIDTH];
            busy        <= 1'b1;
            state       <= CLEAR;
          end
        end
        CLEAR: begin
          // detector held in clear through this cycle; first bit goes
          // out together with releasing the clear
          cnt     <= '0;
          bitcnt  <= '0;
          det_x   <= sreg[WIDTH-1];
          sreg    <= sreg << 1;
          det_clr <= 1'b0;
          state   <= SHIFT;
        end
        SHIFT: begin
          cnt <= cnt_nxt;
          if (last_bit) begin
            // count includes the final bit's det_z
            det_x     <= 1'b0;
            det_clr   <= 1'b1;
            done      <= 1'b1;
            match_cnt <= cnt_nxt;
            done_id   <= job_id;
            state     <= DONE;
          end else begin
            det_x  <= sreg[WIDTH-1];
            sreg   <= sreg << 1;
            bitcnt <= bitcnt + 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Bench for seq_scan_ctrl: drives requests, models the shared 101 detector,
// predicts jobs from arbitration rules and a direct 101 count of each word,
// and checks every cycle plus a done-time scoreboard.
module tb_seq_scan_ctrl;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic [3:0]     req = 4'b0000;
  logic [4*W-1:0] req_data = '0;

  logic [3:0] gnt, gnt1;
  logic       det_x, det_x1, det_z, det_z1, det_clr, det_clr1;
  logic       busy, busy1, done, done1;
  logic [1:0] done_id, done_id1;
  logic [3:0] match_cnt;
  logic [0:0] match_cnt1;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_scan_ctrl #(.WIDTH(W), .CNT_W(4)) u_dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_data(req_data), .gnt(gnt),
    .det_x(det_x), .det_z(det_z), .det_clr(det_clr), .busy(busy), .done(done),
    .done_id(done_id), .match_cnt(match_cnt));

  seq_scan_ctrl #(.WIDTH(W), .CNT_W(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .req(req), .req_data(req_data), .gnt(gnt1),
    .det_x(det_x1), .det_z(det_z1), .det_clr(det_clr1), .busy(busy1), .done(done1),
    .done_id(done_id1), .match_cnt(match_cnt1));

  // overlapping 101 Mealy detector: 0 = idle, 1 = seen 1, 2 = seen 10
  function automatic logic [1:0] dnext(input logic [1:0] s, input logic x);
    if (x) return 2'd1;
    return (s == 2'd1) ? 2'd2 : 2'd0;
  endfunction

  logic [1:0] dst0 = 2'd0, dst1 = 2'd0;
  always @(posedge clk) begin
    dst0 <= det_clr  ? 2'd0 : dnext(dst0, det_x);
    dst1 <= det_clr1 ? 2'd0 : dnext(dst1, det_x1);
  end
  assign det_z  = (dst0 == 2'd2) && det_x;
  assign det_z1 = (dst1 == 2'd2) && det_x1;

  // reference: count overlapping 101 windows in the word, MSB first
  function automatic int count101(input logic [W-1:0] wd);
    int c = 0;
    for (int i = W-1; i >= 2; i--)
      if (wd[i] && !wd[i-1] && wd[i-2]) c++;
    return c;
  endfunction

  function automatic logic [W-1:0] pattern(input int sel);
    case (sel)
      0: return 8'b10100101;
      1: return 8'b10101010;
      2: return 8'b00000000;
      3: return 8'b11111111;
      default: return W'($urandom);
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int         id;
    logic [W-1:0] word;
    int         cnt4;
    int         cnt1;
    int         due;
  } job_t;

  job_t q[$];
  job_t jb;
  int   gnt_log[$];
  int   rel = -1;
  int   lw = 3;
  int   wn, c;
  int   held_cnt = 0, held_cnt1 = 0, held_id = 0;
  logic [W-1:0] cur_word = '0;
  logic [3:0] exp_g;
  logic ebusy, eclr, ex, edone;

  // monitor: per-cycle expectations from job phase, scoreboard pop on done
  always @(negedge clk) begin
    if (!reset_n) begin
      chk("rst_gnt", gnt, 0);          chk("rst_gnt_w1", gnt1, 0);
      chk("rst_det_x", det_x, 0);      chk("rst_det_clr", det_clr, 1);
      chk("rst_busy", busy, 0);        chk("rst_done", done, 0);
      chk("rst_done_w1", done1, 0);    chk("rst_done_id", done_id, 0);
      chk("rst_match_cnt", match_cnt, 0);
      chk("rst_match_cnt_w1", match_cnt1, 0);
      rel = -1; lw = 3; q.delete();
      held_cnt = 0; held_cnt1 = 0; held_id = 0;
    end else begin
      if (rel >= 0) rel++;
      if (rel < 0) begin
        exp_g = 4'b0000;
        wn = lw;
        if (req != 4'b0000) begin
          for (int k = 4; k >= 1; k--)
            if (req[(lw + k) % 4]) wn = (lw + k) % 4;
          exp_g = 4'b0001 << wn;
        end
        chk("gnt", gnt, exp_g);
        chk("gnt_w1", gnt1, exp_g);
        ebusy = 0; eclr = 1; ex = 0; edone = 0;
        if (req != 4'b0000) begin
          jb.id   = wn;
          jb.word = req_data[wn*W +: W];
          c       = count101(jb.word);
          jb.cnt4 = (c > 15) ? 15 : c;
          jb.cnt1 = (c > 1) ? 1 : c;
          jb.due  = cyc + W + 2;
          q.push_back(jb);
          cur_word = jb.word;
          lw = wn;
          gnt_log.push_back(wn);
          rel = 0;
        end
      end else begin
        chk("gnt_busy", gnt, 0);
        chk("gnt_busy_w1", gnt1, 0);
        ebusy = 1;
        eclr  = !(rel >= 2 && rel <= W + 1);
        ex    = (rel >= 2 && rel <= W + 1) ? cur_word[W-1-(rel-2)] : 1'b0;
        edone = (rel == W + 2);
      end
      chk("busy", busy, ebusy);
      chk("det_clr", det_clr, eclr);
      chk("det_x", det_x, ex);
      chk("done", done, edone);
      chk("done_w1", done1, edone);
      if (done) begin
        chk("sb_nonempty", q.size() > 0, 1);
        if (q.size() > 0) begin
          jb = q.pop_front();
          chk("done_cycle", cyc, jb.due);
          chk("done_id", done_id, jb.id);
          chk("match_cnt", match_cnt, jb.cnt4);
          chk("match_cnt_w1", match_cnt1, jb.cnt1);
          held_cnt = jb.cnt4; held_cnt1 = jb.cnt1; held_id = jb.id;
        end
      end else begin
        chk("match_cnt_hold", match_cnt, held_cnt);
        chk("match_cnt_w1_hold", match_cnt1, held_cnt1);
        chk("done_id_hold", done_id, held_id);
      end
      if (rel == W + 2) rel = -1;
    end
  end

  // one cycle of requester behaviour; mode 0 holds requests, 1 drops on
  // grant, 2 drops on grant and raises new random requests
  task automatic step(input int mode);
    logic [3:0] g;
    @(negedge clk);
    g = gnt;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (g[i]) begin
        req_data[i*W +: W] = W'($urandom);
        if (mode != 0) req[i] = 1'b0;
      end else if (mode == 2 && !req[i]) begin
        req_data[i*W +: W] = W'($urandom);
        if ($urandom_range(0, 3) == 0) begin
          req[i] = 1'b1;
          req_data[i*W +: W] = pattern($urandom_range(0, 4));
        end
      end
    end
  endtask

  initial begin
    // all four requesting from reset: lane0 = 10100101, lane1 = 10101010,
    // lane2 = zero word, lane3 random
    req = 4'b1111;
    req_data = {W'($urandom), 8'b00000000, 8'b10101010, 8'b10100101};
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b1;
    for (int n = 0; n < 80 && gnt_log.size() < 5; n++) step(0);
    req = 4'b0000;
    chk("rr_grants", gnt_log.size() >= 5, 1);
    if (gnt_log.size() >= 5)
      for (int i = 0; i < 5; i++) chk("rr_order", gnt_log[i], i % 4);
    repeat (W + 6) step(1);

    // single jobs: alternating word on lane1, zero word on lane2
    req = 4'b0010; req_data[1*W +: W] = 8'b10101010;
    repeat (W + 6) step(1);
    req = 4'b0100; req_data[2*W +: W] = 8'b00000000;
    repeat (W + 6) step(1);

    // abort at the fourth SHIFT cycle, then a clean job from lane0
    req = 4'b0001; req_data[0 +: W] = 8'b10100101;
    step(1);
    repeat (4) @(posedge clk);
    #2 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    req = 4'b0001; req_data[0 +: W] = 8'b10100101;
    repeat (W + 6) step(1);

    // randomized traffic, then drain
    repeat (600) step(2);
    repeat (60) step(1);
    chk("sb_drained", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
